cordic_share_arb: RTL

Round-robin arbiter and result router sharing one pipelined circular-mode CORDIC unit (sine/cosine) among `N` requesters. It accepts one request per cycle and drives the CORDIC start/func/operand inputs. A requester-ID tag travels through a shift pipeline matched to the CORDIC latency. Each result is steered into that requester's response register, where it is held until the requester takes it. The block sits between the CORDIC datapath and its client blocks (e.g. NCO and rotation engines).

---
 rtl/cordic_share_arb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_share_arb.sv
// Round-robin arbiter and result router sharing one pipelined sine/cosine
// CORDIC unit among N requesters. Each requester has at most one operation
// outstanding, so returning results always find a free response register and
// the CORDIC pipeline never stalls. A requester-ID tag rides a shift pipeline
// matched to the CORDIC latency and steers each result to its owner.
module cordic_share_arb #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 12,
    parameter int unsigned LAT = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N-1:0]         req_func,
    input  logic [N*2*W-1:0]     req_a,
    output logic [N-1:0]         resp_valid,
    input  logic [N-1:0]         resp_ready,
    output logic [N*W-1:0]       resp_f,
    output logic                 c_start,
    output logic                 c_func,
    output logic [2*W-1:0]       c_a,
    input  logic                 c_valid,
    input  logic [W-1:0]         c_f,
    output logic                 err
);

    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW  = $clog2(LAT + 1);

    // Outstanding-operation tracking and arbitration state
    logic [N-1:0]     busy;
    logic [N-1:0]     elig;
    logic [N-1:0]     grant;
    logic [N-1:0]     take;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   cand;
    logic             gfound;

    // Operand selected for the winning requester
    logic [2*W-1:0]   sel_a;
    logic             sel_f;

    // ID of the operation currently presented on c_start
    logic [IDW-1:0]   c_id;

    // Tag pipeline: valid bits and requester IDs, tail aligned with c_valid
    logic [LAT-1:0]   tag_v;
    logic [IDW-1:0]   tag_id [LAT];
    logic             tail_v;
    logic [IDW-1:0]   tail_id;

    // Post-reset flush window
    logic [CW-1:0]    flush_cnt;
    logic             flushing;

    logic             capture;

    assign elig     = req_valid & ~busy;
    assign take     = resp_valid & resp_ready;
    assign tail_v   = tag_v[LAT-1];
    assign tail_id  = tag_id[LAT-1];
    assign flushing = (flush_cnt != '0);
    assign capture  = tail_v && c_valid && !flushing;
    assign req_ready = grant;

    // Round-robin search for the first eligible requester after ptr
    always_comb begin
        gfound = 1'b0;
        gidx   = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDW'((32'(ptr) + k) % N);
            if (!gfound && elig[cand]) begin
                gfound = 1'b1;
                gidx   = cand;
            end
        end
        if (rst) begin
            gfound = 1'b0;
        end
        grant = '0;
        if (gfound) begin
            grant[gidx] = 1'b1;
        end
    end

    // Operand and function multiplexer for the granted requester
    always_comb begin
        sel_a = '0;
        sel_f = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gidx == IDW'(i)) begin
                sel_a = req_a[i*2*W +: 2*W];
                sel_f = req_func[i];
            end
        end
    end

    // Registered CORDIC issue and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            c_start <= 1'b0;
            c_func  <= 1'b0;
            c_a     <= '0;
            c_id    <= '0;
            ptr     <= IDW'(N - 1);
        end else begin
            c_start <= gfound;
            if (gfound) begin
                c_func <= sel_f;
                c_a    <= sel_a;
                c_id   <= gidx;
                ptr    <= gidx;
            end
        end
    end

    // Tag shift pipeline loaded in the cycle c_start is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LAT-2:0], c_start};
            tag_id[0] <= c_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Flush counter ignoring results from operations issued before reset
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= CW'(LAT);
        end else if (flushing) begin
            flush_cnt <= flush_cnt - CW'(1);
        end
    end

    // Busy bits: set on request handshake, cleared on response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~take) | grant;
        end
    end

    // Response registers: capture from the tag tail, clear on take
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_f     <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (take[i]) begin
                    resp_valid[i] <= 1'b0;
                end
                if (capture && (tail_id == IDW'(i))) begin
                    resp_valid[i]      <= 1'b1;
                    resp_f[i*W +: W]   <= c_f;
                end
            end
        end
    end

    // Sticky error when the tag tail and c_valid disagree outside the flush
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (!flushing && (tail_v != c_valid)) begin
            err <= 1'b1;
        end
    end

endmodule
